// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement: steps the sprite STEP px per move_tick and queries the legal-move lookup at tile centres.
// Latency: tick to first step is 2 cycles at a centre and 0 off-centre; ticks arriving during QUERY/DECIDE are dropped.
module pacman_move_ctrl #(
  parameter int SF        = 60,
  parameter int S_X       = 150,
  parameter int S_Y       = 34,
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int STEP      = 2,
  parameter int START_COL = 1,
  parameter int START_ROW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       move_tick,
  input  logic [3:0] legal,
  output logic       q_valid,
  output logic [9:0] q_xpos,
  output logic [9:0] q_ypos,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] dir,
  output logic [4:0] tile_col,
  output logic [4:0] tile_row,
  output logic       at_center
);

  localparam int SW = $clog2(SF);
  localparam logic [9:0]    X0       = 10'(S_X + START_COL * SF);
  localparam logic [9:0]    Y0       = 10'(S_Y + START_ROW * SF);
  localparam logic [9:0]    STEP_P   = 10'(STEP);
  localparam logic [SW-1:0] STEP_S   = SW'(STEP);
  localparam logic [SW-1:0] SUB_MAX  = SW'(SF - STEP);
  localparam logic [4:0]    COL0     = 5'(START_COL);
  localparam logic [4:0]    ROW0     = 5'(START_ROW);
  localparam logic [4:0]    LAST_COL = 5'(COLS - 1);
  localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, QUERY, DECIDE} state_t;

  state_t        state;
  logic [3:0]    req;
  logic [SW-1:0] sub;

  logic [3:0]    press;
  logic [3:0]    mask;
  logic [3:0]    new_dir;
  logic [3:0]    opp;
  logic          rev;
  logic [3:0]    step_dir;
  logic          do_step;
  logic [9:0]    nx, ny;
  logic [4:0]    nc, nr;
  logic [SW-1:0] ns;

  always_comb begin
    press = 4'b0000;
    if (btn_l)      press = 4'b1000;
    else if (btn_r) press = 4'b0100;
    else if (btn_u) press = 4'b0010;
    else if (btn_d) press = 4'b0001;
  end

  // Grid edges override whatever the lookup claims.
  always_comb begin
    mask = legal;
    if (tile_col == 5'd0)     mask[3] = 1'b0;
    if (tile_col == LAST_COL) mask[2] = 1'b0;
    if (tile_row == 5'd0)     mask[1] = 1'b0;
    if (tile_row == LAST_ROW) mask[0] = 1'b0;
    if ((req & mask) != 4'b0000)      new_dir = req;
    else if ((dir & mask) != 4'b0000) new_dir = dir;
    else                              new_dir = 4'b0000;
  end

  assign opp      = {dir[2], dir[3], dir[0], dir[1]};
  assign rev      = (dir != 4'b0000) && (req == opp);
  assign step_dir = (state == DECIDE) ? new_dir : (rev ? req : dir);
  assign do_step  = (state == DECIDE) || (state == IDLE && move_tick && !at_center);

  // sub is always the offset in the +x/+y sense from the tile's top-left, so reversal needs no fix-up.
  always_comb begin
    nx = xpos;
    ny = ypos;
    nc = tile_col;
    nr = tile_row;
    ns = sub;
    if (step_dir[2]) begin
      nx = xpos + STEP_P;
      if (sub == SUB_MAX) begin
        ns = '0;
        nc = tile_col + 5'd1;
      end else begin
        ns = sub + STEP_S;
      end
    end else if (step_dir[3]) begin
      nx = xpos - STEP_P;
      if (sub == '0) begin
        ns = SUB_MAX;
        nc = tile_col - 5'd1;
      end else begin
        ns = sub - STEP_S;
      end
    end else if (step_dir[0]) begin
      ny = ypos + STEP_P;
      if (sub == SUB_MAX) begin
        ns = '0;
        nr = tile_row + 5'd1;
      end else begin
        ns = sub + STEP_S;
      end
    end else if (step_dir[1]) begin
      ny = ypos - STEP_P;
      if (sub == '0) begin
        ns = SUB_MAX;
        nr = tile_row - 5'd1;
      end else begin
        ns = sub - STEP_S;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req       <= 4'b0000;
      dir       <= 4'b0000;
      sub       <= '0;
      xpos      <= X0;
      ypos      <= Y0;
      tile_col  <= COL0;
      tile_row  <= ROW0;
      at_center <= 1'b1;
      q_valid   <= 1'b0;
      q_xpos    <= X0;
      q_ypos    <= Y0;
    end else begin
      if (press != 4'b0000) req <= press;
      q_valid <= 1'b0;

      if (do_step) begin
        dir       <= step_dir;
        xpos      <= nx;
        ypos      <= ny;
        tile_col  <= nc;
        tile_row  <= nr;
        sub       <= ns;
        at_center <= (ns == '0);
      end

      case (state)
        IDLE: begin
          if (move_tick && at_center) begin
            // At a centre the sprite position is exactly the tile's top-left.
            state   <= QUERY;
            q_valid <= 1'b1;
            q_xpos  <= xpos;
            q_ypos  <= ypos;
          end
        end
        QUERY:   state <= DECIDE;
        DECIDE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl: table of tick runs plus hand-written latency and reset sequences.
module tb_pacman_move_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_l, btn_r, btn_u, btn_d;
  logic       move_tick;
  logic [3:0] legal;
  logic       q_valid;
  logic [9:0] q_xpos, q_ypos, xpos, ypos;
  logic [3:0] dir;
  logic [4:0] tile_col, tile_row;
  logic       at_center;

  pacman_move_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .move_tick (move_tick),
    .legal     (legal),
    .q_valid   (q_valid),
    .q_xpos    (q_xpos),
    .q_ypos    (q_ypos),
    .xpos      (xpos),
    .ypos      (ypos),
    .dir       (dir),
    .tile_col  (tile_col),
    .tile_row  (tile_row),
    .at_center (at_center)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;   // {l,r,u,d} pressed for one cycle before the ticks
    logic [3:0] lg;
    int         ticks;
    int         nq;    // queries expected during this row, all at (qx,qy)
    int         qx, qy;
    int         x, y;
    logic [3:0] d;
    int         col, row;
    logic       atc;
  } vec_t;

  vec_t       vecs[10];
  logic [19:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called every negedge: each observed query strobe is matched against the scoreboard.
  task automatic watch_query();
    logic [19:0] e;
    if (q_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_query", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("query_x", int'(q_xpos), int'(e[19:10]));
        check("query_y", int'(q_ypos), int'(e[9:0]));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    watch_query();
  endtask

  task automatic tick();
    move_tick = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      move_tick = 1'b0;
      watch_query();
    end
  endtask

  task automatic press(input logic [3:0] b);
    {btn_l, btn_r, btn_u, btn_d} = b;
    cycle();
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int d,
                           input int col, input int row, input int atc);
    check({tag, "_x"},   int'(xpos), x);
    check({tag, "_y"},   int'(ypos), y);
    check({tag, "_dir"}, int'(dir), d);
    check({tag, "_col"}, int'(tile_col), col);
    check({tag, "_row"}, int'(tile_row), row);
    check({tag, "_atc"}, int'(at_center), atc);
  endtask

  initial begin
    rst = 1'b1;
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    move_tick = 1'b0;
    legal = 4'b0000;

    vecs[0] = '{4'b0000, 4'b0100, 29, 0,   0,  0, 270,  34, 4'b0100, 2, 0, 1'b1};
    vecs[1] = '{4'b0010, 4'b0100, 10, 1, 270, 34, 290,  34, 4'b0100, 2, 0, 1'b0};
    vecs[2] = '{4'b1000, 4'b0100,  1, 0,   0,  0, 288,  34, 4'b1000, 2, 0, 1'b0};
    vecs[3] = '{4'b0000, 4'b0100,  9, 0,   0,  0, 270,  34, 4'b1000, 2, 0, 1'b1};
    vecs[4] = '{4'b0000, 4'b1000, 30, 1, 270, 34, 210,  34, 4'b1000, 1, 0, 1'b1};
    vecs[5] = '{4'b0000, 4'b1000, 30, 1, 210, 34, 150,  34, 4'b1000, 0, 0, 1'b1};
    vecs[6] = '{4'b0000, 4'b1001,  3, 3, 150, 34, 150,  34, 4'b0000, 0, 0, 1'b1};
    vecs[7] = '{4'b0001, 4'b0001, 30, 1, 150, 34, 150,  94, 4'b0001, 0, 1, 1'b1};
    vecs[8] = '{4'b1000, 4'b1001,  1, 1, 150, 94, 150,  96, 4'b0001, 0, 1, 1'b0};
    vecs[9] = '{4'b0000, 4'b1001,  4, 0,   0,  0, 150, 104, 4'b0001, 0, 1, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_q_valid", int'(q_valid), 0);
    check_pos("rst", 210, 34, 0, 1, 0, 1);
    rst = 1'b0;
    cycle();

    // First move from a centre: query one cycle after the tick, first step two cycles after.
    press(4'b0100);
    legal = 4'b0100;
    exp_q.push_back({10'd210, 10'd34});
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    check("lat_q_valid_c1", int'(q_valid), 1);
    watch_query();
    check("lat_x_c1", int'(xpos), 210);
    @(negedge clk);
    check("lat_q_valid_c2", int'(q_valid), 0);
    check("lat_x_c2", int'(xpos), 210);
    @(negedge clk);
    check("lat_x_c3", int'(xpos), 212);
    check("lat_dir_c3", int'(dir), 4);
    check("lat_atc_c3", int'(at_center), 0);
    cycle();
    cycle();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].btn != 4'b0000) press(vecs[i].btn);
      else cycle();
      legal = vecs[i].lg;
      for (int q = 0; q < vecs[i].nq; q++)
        exp_q.push_back({10'(vecs[i].qx), 10'(vecs[i].qy)});
      for (int t = 0; t < vecs[i].ticks; t++) begin
        tick();
        check($sformatf("row%0d_t%0d_xmin", i, t), int'(xpos >= 10'd150), 1);
      end
      check_pos($sformatf("row%0d", i), vecs[i].x, vecs[i].y, int'(vecs[i].d),
                vecs[i].col, vecs[i].row, int'(vecs[i].atc));
    end

    // Asynchronous reset mid-tile (sub = 10), sampled well before the next clock edge.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q_valid", int'(q_valid), 0);
    check_pos("mid_rst", 210, 34, 0, 1, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    legal = 4'b0100;
    exp_q.push_back({10'd210, 10'd34});
    tick();
    check_pos("post_rst", 210, 34, 0, 1, 0, 1);

    check("queries_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
